// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit that owns HI/LO: shift-add multiply, restoring divide.
// Latency 33 clocks from the start edge. Starts and MTHI/MTLO writes arriving while busy are dropped.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] opr_a_md_i,
   input  logic [31:0] opr_b_md_i,
   input  logic [1:0]  op_md_i,
   input  logic        start_md_i,
   input  logic        hi_we_md_i,
   input  logic        lo_we_md_i,
   input  logic [31:0] wdata_md_i,
   output logic [31:0] hi_md_o,
   output logic [31:0] lo_md_o,
   output logic        busy_md_o,
   output logic        done_md_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] opb_q, opb_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        is_signed;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum;
   logic [32:0] rem_shift, rem_sub;
   logic        q_bit;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      is_signed = ~op_md_i[0];
      mag_a     = (is_signed && opr_a_md_i[31]) ? (32'd0 - opr_a_md_i) : opr_a_md_i;
      mag_b     = (is_signed && opr_b_md_i[31]) ? (32'd0 - opr_b_md_i) : opr_b_md_i;

      // Multiply: acc holds {partial product, remaining multiplier bits}.
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

      // Divide: acc[31:0] shifts the dividend out and the quotient in.
      rem_shift = {rem_q, acc_q[31]};
      rem_sub   = rem_shift - {1'b0, opb_q};
      q_bit     = ~rem_sub[32];

      prod_fix  = neg_res_q ? (64'd0 - acc_q) : acc_q;
      quo_fix   = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem_fix   = neg_rem_q ? (32'd0 - rem_q) : rem_q;

      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (!busy_q && hi_we_md_i) hi_d = wdata_md_i;
      if (!busy_q && lo_we_md_i) lo_d = wdata_md_i;

      case (state_q)
         S_IDLE: begin
            if (start_md_i) begin
               state_d   = S_CALC;
               cnt_d     = 5'd0;
               is_div_d  = op_md_i[1];
               // A zero divisor keeps the quotient positive so it stays all ones;
               // the remainder negation then just restores the original dividend.
               neg_res_d = is_signed && (opr_a_md_i[31] ^ opr_b_md_i[31]) && (opr_b_md_i != 32'd0);
               neg_rem_d = is_signed && opr_a_md_i[31];
               opb_d     = op_md_i[1] ? mag_b : mag_a;
               acc_d     = op_md_i[1] ? {32'd0, mag_a} : {32'd0, mag_b};
               rem_d     = 32'd0;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_q) begin
               acc_d[31:0] = {acc_q[30:0], q_bit};
               rem_d       = q_bit ? rem_sub[31:0] : rem_shift[31:0];
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (is_div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opb_q     <= 32'd0;
         acc_q     <= 64'd0;
         rem_q     <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opb_q     <= opb_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign hi_md_o   = hi_q;
   assign lo_md_o   = lo_q;
   assign busy_md_o = busy_q;
   assign done_md_o = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and random ops against an arithmetic reference model.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] opr_a, opr_b, wdata;
   logic [1:0]  op_md;
   logic        start, hi_we, lo_we;
   logic [31:0] hi_md_o, lo_md_o;
   logic        busy_md_o, done_md_o;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opr_a_md_i (opr_a),
      .opr_b_md_i (opr_b),
      .op_md_i    (op_md),
      .start_md_i (start),
      .hi_we_md_i (hi_we),
      .lo_we_md_i (lo_we),
      .wdata_md_i (wdata),
      .hi_md_o    (hi_md_o),
      .lo_md_o    (lo_md_o),
      .busy_md_o  (busy_md_o),
      .done_md_o  (done_md_o)
   );

   // Directed vectors: op, a, b, expected HI, expected LO.
   logic [1:0]  d_op [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
   logic [31:0] d_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100,
                             32'h80000000, 32'd5, 32'hFFFFFFF9};
   logic [31:0] d_b  [7] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
   logic [31:0] d_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                             32'd0, 32'd5, 32'hFFFFFFF9};
   logic [31:0] d_lo [7] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14,
                             32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      int          ia, ib;
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         2'd0: begin
            p  = sa * sb;
            up = p;
            hi = up[63:32];
            lo = up[31:0];
         end
         2'd1: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFFFFFF;
            end else if (op == 2'd2) begin
               q  = sa / sb;
               r  = sa % sb;
               up = q;
               lo = up[31:0];
               up = r;
               hi = up[31:0];
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'd1;
         4:       return $urandom_range(1, 20);
         5:       return 32'd0 - $urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   // Issues one op (caller is just past a rising edge) and waits for done, bounded.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int edges, output int busy_cnt, output int overlap);
      opr_a = a; opr_b = b; op_md = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; opr_a = $urandom; opr_b = $urandom; op_md = 2'($urandom);
      edges    = 0;
      overlap  = 0;
      busy_cnt = busy_md_o ? 1 : 0;
      while (!done_md_o && edges < 100) begin
         @(posedge clk); #1;
         edges++;
         if (busy_md_o) busy_cnt++;
         if (busy_md_o && done_md_o) overlap++;
      end
      hi = hi_md_o;
      lo = lo_md_o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      opr_a = 32'd0; opr_b = 32'd0; op_md = 2'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({hi_md_o, lo_md_o, busy_md_o, done_md_o} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required all zero",
                  hi_md_o, lo_md_o, busy_md_o, done_md_o);
      end
   endtask

   task automatic test_directed();
      logic [31:0] hi, lo;
      int          e, bc, ov;
      for (int i = 0; i < 7; i++) begin
         do_op(d_op[i], d_a[i], d_b[i], hi, lo, e, bc, ov);
         vectors++;
         if (hi !== d_hi[i] || lo !== d_lo[i]) begin
            miscompares++;
            $display("FAIL directed_%0d: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, d_hi[i], d_lo[i]);
         end
         vectors++;
         if (e !== 33) begin
            miscompares++;
            $display("FAIL directed_latency_%0d: %0d clocks, required 33", i, e);
         end
         if (i == 0) begin
            vectors++;
            if (bc !== 33 || ov !== 0) begin
               miscompares++;
               $display("FAIL busy_window: busy %0d cycles overlap %0d, required 33 and 0", bc, ov);
            end
            @(posedge clk); #1;
            vectors++;
            if (done_md_o !== 1'b0 || busy_md_o !== 1'b0) begin
               miscompares++;
               $display("FAIL done_pulse_width: done=%b busy=%b after pulse, required 0 0",
                        done_md_o, busy_md_o);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, hi, lo, ehi, elo;
      logic [1:0]  op;
      int          e, bc, ov;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         model(op, a, b, ehi, elo);
         do_op(op, a, b, hi, lo, e, bc, ov);
         vectors++;
         if (hi !== ehi || lo !== elo || e !== 33) begin
            miscompares++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=33",
                     i, op, a, b, hi, lo, e, ehi, elo);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] ehi, elo, hi, lo;
      int          dcount, dedge;
      model(2'd1, 32'h12345678, 32'h9ABCDEF0, ehi, elo);
      opr_a = 32'h12345678; opr_b = 32'h9ABCDEF0; op_md = 2'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dcount = 0; dedge = 0; hi = 32'd0; lo = 32'd0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk); #1;
         if (done_md_o) begin
            dcount++;
            dedge = i;
            hi = hi_md_o;
            lo = lo_md_o;
         end
         if (i == 10) begin
            start = 1'b1; op_md = 2'd3; opr_a = 32'd99; opr_b = 32'd4;
            hi_we = 1'b1; wdata = 32'h1234;
         end else if (i == 11) begin
            start = 1'b0; hi_we = 1'b0;
         end
      end
      vectors++;
      if (dcount !== 1 || dedge !== 33) begin
         miscompares++;
         $display("FAIL busy_ignore_done: %0d pulses at clock %0d, required 1 at 33", dcount, dedge);
      end
      vectors++;
      if (hi !== ehi || lo !== elo || hi_md_o !== ehi) begin
         miscompares++;
         $display("FAIL busy_ignore_result: hi=%h lo=%h final hi=%h, required hi=%h lo=%h",
                  hi, lo, hi_md_o, ehi, elo);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] hi, lo, ehi, elo;
      int          e, bc, ov;
      do_op(2'd3, 32'd1000, 32'd33, hi, lo, e, bc, ov);
      vectors++;
      if (hi !== 32'd10 || lo !== 32'd30 || e !== 33) begin
         miscompares++;
         $display("FAIL b2b_first: hi=%h lo=%h lat=%0d, required hi=a lo=1e lat=33", hi, lo, e);
      end
      model(2'd0, 32'hFFFF0000, 32'h00012345, ehi, elo);
      do_op(2'd0, 32'hFFFF0000, 32'h00012345, hi, lo, e, bc, ov);
      vectors++;
      if (hi !== ehi || lo !== elo || e !== 33 || bc !== 33) begin
         miscompares++;
         $display("FAIL b2b_second: hi=%h lo=%h lat=%0d busy=%0d, required hi=%h lo=%h lat=33 busy=33",
                  hi, lo, e, bc, ehi, elo);
      end
   endtask

   task automatic test_mt_writes();
      logic [31:0] ehi, elo;
      int          e;
      hi_we = 1'b1; wdata = 32'hA5A5_0001;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
      vectors++;
      if (hi_md_o !== 32'hA5A5_0001) begin
         miscompares++;
         $display("FAIL mthi_idle: hi=%h, required a5a50001", hi_md_o);
      end
      @(posedge clk); #1;
      lo_we = 1'b0;
      vectors++;
      if (lo_md_o !== 32'h5A5A_0002 || hi_md_o !== 32'hA5A5_0001) begin
         miscompares++;
         $display("FAIL mtlo_idle: hi=%h lo=%h, required a5a50001 5a5a0002", hi_md_o, lo_md_o);
      end
      model(2'd2, 32'hFFFFFC18, 32'd7, ehi, elo);
      opr_a = 32'hFFFFFC18; opr_b = 32'd7; op_md = 2'd2; start = 1'b1;
      hi_we = 1'b1; wdata = 32'h0BAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      vectors++;
      if (hi_md_o !== 32'h0BAD_BEEF || busy_md_o !== 1'b1) begin
         miscompares++;
         $display("FAIL mthi_with_start: hi=%h busy=%b, required 0badbeef 1", hi_md_o, busy_md_o);
      end
      e = 0;
      while (!done_md_o && e < 100) begin
         @(posedge clk); #1;
         e++;
      end
      vectors++;
      if (hi_md_o !== ehi || lo_md_o !== elo || e !== 33) begin
         miscompares++;
         $display("FAIL mthi_overwritten: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=33",
                  hi_md_o, lo_md_o, e, ehi, elo);
      end
   endtask

   task automatic test_mid_reset();
      int dcount, bcount;
      opr_a = 32'hFFFFFFFF; opr_b = 32'hFFFFFFFF; op_md = 2'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({hi_md_o, lo_md_o, busy_md_o, done_md_o} !== 66'd0) begin
         miscompares++;
         $display("FAIL mid_reset_state: hi=%h lo=%h busy=%b done=%b, required all zero",
                  hi_md_o, lo_md_o, busy_md_o, done_md_o);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      dcount = 0; bcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_md_o) dcount++;
         if (busy_md_o) bcount++;
      end
      vectors++;
      if (dcount !== 0 || bcount !== 0 || hi_md_o !== 32'd0 || lo_md_o !== 32'd0) begin
         miscompares++;
         $display("FAIL mid_reset_abort: done %0d busy %0d hi=%h lo=%h, required 0 0 0 0",
                  dcount, bcount, hi_md_o, lo_md_o);
      end
      lo_we = 1'b1; wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      lo_we = 1'b0;
      vectors++;
      if (lo_md_o !== 32'hCAFEF00D || hi_md_o !== 32'd0) begin
         miscompares++;
         $display("FAIL mtlo_after_reset: lo=%h hi=%h, required cafef00d 0", lo_md_o, hi_md_o);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_mt_writes();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, covering MULT, MULTU, DIV and DIVU. It owns the architectural HI/LO registers.
- The single-cycle ALU returns a result the same cycle; this block instead accepts an operation with a start pulse, reports busy while it iterates, and pulses done when HI/LO hold the result.
- It sits beside the ALU in the execute stage, takes the same two register-file operands, and feeds HI/LO back for MFHI/MFLO.

## Interface
Parameters:
- none; width is fixed at 32 bits, iteration count is fixed at 32.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- opr_a_md_i  in  32  multiplicand / dividend (rs).
- opr_b_md_i  in  32  multiplier / divisor (rt).
- op_md_i  in  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- start_md_i  in  1  request; sampled only in IDLE.
- hi_we_md_i  in  1  MTHI write enable.
- lo_we_md_i  in  1  MTLO write enable.
- wdata_md_i  in  32  MTHI/MTLO data.
- hi_md_o  out  32  HI register.
- lo_md_o  out  32  LO register.
- busy_md_o  out  1  high while an operation is in flight.
- done_md_o  out  1  one-cycle pulse when HI/LO were just updated by an operation.

## Operation
States: IDLE, CALC, FIX.

IDLE
- On start_md_i=1, latch the operation and operand magnitudes, clear the iteration counter, and go to CALC.
- Signed ops (op_md_i[0]=0) take two's-complement magnitudes and record the result signs:
  - product/quotient sign = a[31]^b[31];
  - remainder sign = a[31].
- Unsigned ops use the operands as-is, with both signs 0.

CALC (exactly 32 cycles, counter 0..31)
- Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- When the counter reaches 31, go to FIX.

FIX (1 cycle)
- Apply the sign correction (two's-complement negate where the recorded sign is 1).
- Write results:
  - multiply: HI = product[63:32], LO = product[31:0];
  - divide: LO = quotient, HI = remainder.
- Pulse done_md_o and return to IDLE.

Arithmetic rules
- Results are taken modulo 2^32 per register.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (all div ops) gives LO=0xFFFFFFFF and HI=dividend as presented. For DIV this is with no sign fix on HI. Latency is normal.

MTHI/MTLO
- Accepted only when busy_md_o=0. HI/LO update at that clock edge; writes while busy are dropped.
- start_md_i together with a write in IDLE: the write is applied, then overwritten when the operation completes.

start_md_i while busy is ignored, with no queueing. Operand inputs are don't-care after the start edge.

## Timing
- Reset values: hi_md_o=0, lo_md_o=0, busy_md_o=0, done_md_o=0, state IDLE. Assertion of rst_n=0 mid-operation aborts it immediately, with no done pulse.
- Start accepted at edge E0:
  - busy_md_o=1 from E0 until E33;
  - iterations occur at edges E1..E32;
  - FIX executes at E33: HI/LO update, done_md_o=1 and busy_md_o=0 for the cycle following E33.
- Latency is 33 clocks from the start edge to the result. A new start is accepted in the same cycle that done_md_o is high, since state is IDLE.
- busy_md_o and done_md_o are registered; they are never high together.
- hi_md_o/lo_md_o change only at reset, at an accepted MTHI/MTLO, or at E33.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 clocks HI=0xFFFFFFFE, LO=0x00000001; done high for 1 cycle; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) × 0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV -7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Second start and MTHI 0x1234 pulsed at cycle 10 of a busy op → both ignored; final HI/LO from the first op only, one done pulse.
- Back-to-back: start asserted in the done cycle → accepted; second result appears 33 clocks later.
- rst_n low at cycle 15 of a MULTU → HI=LO=0, busy=0, no done; after release, MTLO 0xCAFEF00D → lo_md_o=0xCAFEF00D the next cycle.
